// File: rtl/iob_axi_burst_master_if.sv
// rtl/iob_axi_burst_master_if.sv - AXI4 master bus bundle (AW/W/B/AR/R) for the burst master
interface iob_axi_burst_master_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              m_axi_awid;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awlock;
    logic [3:0]        m_axi_awcache;
    logic [2:0]        m_axi_awprot;
    logic [3:0]        m_axi_awqos;
    logic              m_axi_awvalid;
    logic              m_axi_awready;

    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;

    logic       m_axi_bid;
    logic [1:0] m_axi_bresp;
    logic       m_axi_bvalid;
    logic       m_axi_bready;

    logic              m_axi_arid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic              m_axi_arvalid;
    logic              m_axi_arready;

    logic              m_axi_rid;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/iob_axi_burst_master.sv
// rtl/iob_axi_burst_master.sv - single-outstanding AXI4 INCR burst master with command and data streams
module iob_axi_burst_master #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic                wr_valid,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                wr_ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                rd_ready,
    output logic                done,
    output logic                err,
    iob_axi_burst_master_if.master m_axi
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [8:0]        beat_q;
    logic              awvalid_q;
    logic              arvalid_q;
    logic [13:0]       end_off;
    logic              crosses_4k;
    logic              last_beat;
    logic              w_act;
    logic              r_act;
    logic              unused_ok;

    // Offset one past the final byte of the burst inside its 4 KB page.
    assign end_off    = {2'b00, cmd_addr[11:2], 2'b00} + {3'b000, ({1'b0, cmd_len} + 9'd1), 2'b00};
    assign crosses_4k = end_off > 14'd4096;
    assign last_beat  = beat_q == {1'b0, len_q};
    assign w_act      = state == S_W;
    assign r_act      = state == S_R;

    assign m_axi.m_axi_awid    = 1'b0;
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awlen   = len_q;
    assign m_axi.m_axi_awsize  = 3'b010;
    assign m_axi.m_axi_awburst = 2'b01;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = 4'b0011;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_awqos   = 4'b0000;
    assign m_axi.m_axi_awvalid = awvalid_q;

    assign m_axi.m_axi_arid    = 1'b0;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_arlen   = len_q;
    assign m_axi.m_axi_arsize  = 3'b010;
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_arlock  = 1'b0;
    assign m_axi.m_axi_arcache = 4'b0011;
    assign m_axi.m_axi_arprot  = 3'b000;
    assign m_axi.m_axi_arqos   = 4'b0000;
    assign m_axi.m_axi_arvalid = arvalid_q;

    assign m_axi.m_axi_wvalid = w_act & wr_valid;
    assign m_axi.m_axi_wdata  = wr_data;
    assign m_axi.m_axi_wstrb  = wr_strb;
    assign m_axi.m_axi_wlast  = w_act & last_beat;
    assign wr_ready           = w_act & m_axi.m_axi_wready;

    assign m_axi.m_axi_bready = state == S_B;

    assign rd_valid           = r_act & m_axi.m_axi_rvalid;
    assign rd_data            = m_axi.m_axi_rdata;
    assign m_axi.m_axi_rready = r_act & rd_ready;

    // IDs are always 0 on issue, so returned IDs carry no information.
    assign unused_ok = &{1'b0, m_axi.m_axi_bid, m_axi.m_axi_rid, cmd_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        len_q     <= cmd_len;
                        beat_q    <= '0;
                        err       <= 1'b0;
                        if (crosses_4k) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (cmd_dir) begin
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end else begin
                            awvalid_q <= 1'b1;
                            state     <= S_AW;
                        end
                    end
                end
                S_AW: begin
                    if (m_axi.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi.m_axi_wvalid && m_axi.m_axi_wready) begin
                        beat_q <= beat_q + 9'd1;
                        if (last_beat) state <= S_B;
                    end
                end
                S_B: begin
                    if (m_axi.m_axi_bvalid) begin
                        if (m_axi.m_axi_bresp != 2'b00) err <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_AR: begin
                    if (m_axi.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (m_axi.m_axi_rvalid && m_axi.m_axi_rready) begin
                        beat_q <= beat_q + 9'd1;
                        // A missing or premature rlast means the slave disagrees on burst length.
                        if ((m_axi.m_axi_rresp != 2'b00) || (m_axi.m_axi_rlast != last_beat))
                            err <= 1'b1;
                        if (m_axi.m_axi_rlast) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_axi_burst_master.sv
// tb/tb_iob_axi_burst_master.sv - directed self-checking bench with a small AXI slave memory
module tb_iob_axi_burst_master;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_dir;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid, wr_ready, rd_valid, rd_ready, done, err;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [3:0]        wr_strb;

    iob_axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

    iob_axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .done(done), .err(err), .m_axi(m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave / monitor state
    int          cyc, acc_cyc, b_cyc, rl_cyc, done_cyc;
    bit          acc_seen, w_early, b_pending, r_active;
    int          aw_count, ar_count, w_beats, wlast_n, wlast_at, rd_beats, done_n, r_beat;
    logic [23:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic [9:0]  w_word, r_word;
    logic [1:0]  cfg_bresp;
    int          cfg_rlast_at;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_log [0:15];
    logic [31:0] wbase;
    bit          rd_tog, wr_gap, err_after_acc;

    // Slave drives on the falling edge, observes 1 ns later; handshakes land on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                b_pending = 1'b0;
                r_active  = 1'b0;
            end
            m.m_axi_bid    = 1'b0;
            m.m_axi_bvalid = b_pending;
            m.m_axi_bresp  = cfg_bresp;
            m.m_axi_rid    = 1'b0;
            m.m_axi_rresp  = 2'b00;
            m.m_axi_rvalid = r_active;
            m.m_axi_rdata  = mem[r_word + 10'(r_beat)];
            m.m_axi_rlast  = r_active && (r_beat == cfg_rlast_at);
            #1;
            cyc++;
            if (rst) begin
                if (cmd_valid && cmd_ready) begin acc_seen = 1'b1; acc_cyc = cyc; end
                if (m.m_axi_awvalid && m.m_axi_awready) begin
                    aw_count++;
                    aw_addr = m.m_axi_awaddr; aw_len = m.m_axi_awlen; aw_size = m.m_axi_awsize;
                    aw_burst = m.m_axi_awburst; aw_cache = m.m_axi_awcache;
                    w_word = m.m_axi_awaddr[11:2];
                end
                if (m.m_axi_wvalid && m.m_axi_wready) begin
                    if (aw_count == 0) w_early = 1'b1;
                    mem[w_word + 10'(w_beats)] = m.m_axi_wdata;
                    if (m.m_axi_wlast) begin wlast_n++; wlast_at = w_beats; b_pending = 1'b1; end
                    w_beats++;
                end
                if (m.m_axi_bvalid && m.m_axi_bready) begin b_cyc = cyc; b_pending = 1'b0; end
                if (m.m_axi_arvalid && m.m_axi_arready) begin
                    ar_count++;
                    ar_addr = m.m_axi_araddr; ar_len = m.m_axi_arlen;
                    r_word = m.m_axi_araddr[11:2]; r_beat = 0; r_active = 1'b1;
                end
                if (rd_valid && rd_ready) begin
                    if (rd_beats < 16) rd_log[rd_beats] = rd_data;
                    rd_beats++;
                end
                if (m.m_axi_rvalid && m.m_axi_rready) begin
                    if (m.m_axi_rlast) begin r_active = 1'b0; rl_cyc = cyc; end
                    r_beat++;
                end
                if (done) begin done_n++; done_cyc = cyc; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        wr_data  = wbase + 32'(w_beats);
        wr_strb  = 4'hF;
        wr_valid = wr_gap ? ~wr_valid : 1'b1;
        rd_ready = rd_tog ? ~rd_ready : 1'b1;
    endtask

    task automatic issue(input logic dir, input logic [23:0] addr, input logic [7:0] len);
        acc_seen = 0; w_early = 0; aw_count = 0; ar_count = 0; w_beats = 0; wlast_n = 0;
        wlast_at = -1; rd_beats = 0; done_n = 0; acc_cyc = -1; b_cyc = -1; rl_cyc = -1; done_cyc = -1;
        wr_data  = wbase;
        cmd_dir  = dir; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc_seen) break;
        end
        cmd_valid     = 1'b0;
        err_after_acc = err;
        check("cmd_accepted", 64'(acc_seen), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_n > 0) begin seen = 1'b1; break; end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick();
        tick();
        check({tag, "_done_once"}, 64'(done_n), 64'd1);
    endtask

    initial begin
        cmd_valid = 0; cmd_dir = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        wbase = 32'h0; rd_tog = 0; wr_gap = 0; cfg_bresp = 2'b00; cfg_rlast_at = 0;
        cyc = 0; b_pending = 0; r_active = 0; r_beat = 0; w_word = '0; r_word = '0;
        w_beats = 0; done_n = 0;
        m.m_axi_awready = 1'b1; m.m_axi_wready = 1'b1; m.m_axi_arready = 1'b1;
        m.m_axi_bid = 1'b0; m.m_axi_bresp = 2'b00; m.m_axi_bvalid = 1'b0;
        m.m_axi_rid = 1'b0; m.m_axi_rdata = '0; m.m_axi_rresp = 2'b00;
        m.m_axi_rlast = 1'b0; m.m_axi_rvalid = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", 64'({cmd_ready, done, err, wr_ready, rd_valid, m.m_axi_awvalid,
              m.m_axi_wvalid, m.m_axi_bready, m.m_axi_arvalid, m.m_axi_rready}), 64'd0);
        check("rst_addr_reg", 64'(m.m_axi_awaddr), 64'd0);
        rst = 1'b1;
        tick();
        check("cmd_ready_first_edge", 64'(cmd_ready), 64'd1);

        // Write 0x100, 4 beats
        wbase = 32'hA0;
        issue(1'b0, 24'h000100, 8'd3);
        wait_done("wr1");
        check("wr1_aw_count", 64'(aw_count), 64'd1);
        check("wr1_awaddr", 64'(aw_addr), 64'h100);
        check("wr1_awlen", 64'(aw_len), 64'd3);
        check("wr1_aw_consts", 64'({aw_size, aw_burst, aw_cache}), 64'({3'b010, 2'b01, 4'b0011}));
        check("wr1_beats", 64'(w_beats), 64'd4);
        check("wr1_wlast", 64'({wlast_n[7:0], wlast_at[7:0]}), 64'h0103);
        check("wr1_w_before_aw", 64'(w_early), 64'd0);
        check("wr1_done_latency", 64'(done_cyc), 64'(b_cyc + 1));
        check("wr1_err", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) check("wr1_mem", 64'(mem[10'h040 + 10'(i)]), 64'(32'hA0 + i));

        // Read back from an unaligned address with a throttled consumer
        rd_tog = 1; cfg_rlast_at = 3;
        issue(1'b1, 24'h000103, 8'd3);
        wait_done("rd1");
        rd_tog = 0;
        check("rd1_ar_count", 64'(ar_count), 64'd1);
        check("rd1_araddr_aligned", 64'(ar_addr), 64'h100);
        check("rd1_arlen", 64'(ar_len), 64'd3);
        check("rd1_beats", 64'(rd_beats), 64'd4);
        for (int i = 0; i < 4; i++) check("rd1_data", 64'(rd_log[i]), 64'(32'hA0 + i));
        check("rd1_done_latency", 64'(done_cyc), 64'(rl_cyc + 1));
        check("rd1_err", 64'(err), 64'd0);

        // 4 KB crossing: 0xFF0 + 32 bytes
        issue(1'b0, 24'h000FF0, 8'd7);
        wait_done("x4k");
        check("x4k_no_aw", 64'(aw_count), 64'd0);
        check("x4k_no_w", 64'(w_beats), 64'd0);
        check("x4k_done_latency", 64'(done_cyc), 64'(acc_cyc + 1));
        check("x4k_err", 64'(err), 64'd1);

        // Burst ending exactly at the 4 KB boundary is legal
        wbase = 32'hB0; wr_gap = 1;
        issue(1'b0, 24'h000FE0, 8'd7);
        wait_done("edge4k");
        wr_gap = 0;
        check("edge4k_aw_count", 64'(aw_count), 64'd1);
        check("edge4k_beats", 64'(w_beats), 64'd8);
        check("edge4k_wlast_at", 64'(wlast_at), 64'd7);
        check("edge4k_mem_last", 64'(mem[10'h3FF]), 64'h B7);
        check("edge4k_err", 64'(err), 64'd0);

        // SLVERR on B; err sticky until the next accept
        wbase = 32'hD0; cfg_bresp = 2'b10;
        issue(1'b0, 24'h000200, 8'd0);
        wait_done("bresp");
        check("bresp_err", 64'(err), 64'd1);
        repeat (3) tick();
        check("bresp_err_sticky", 64'(err), 64'd1);
        cfg_bresp = 2'b00; cfg_rlast_at = 0;
        issue(1'b1, 24'h000200, 8'd0);
        check("err_clear_on_accept", 64'(err_after_acc), 64'd0);
        wait_done("rd2");
        check("rd2_data", 64'(rd_log[0]), 64'hD0);
        check("rd2_err", 64'(err), 64'd0);

        // Reset during the 2nd W beat of an 8-beat write
        wbase = 32'hE0;
        issue(1'b0, 24'h000300, 8'd7);
        for (int i = 0; i < 50; i++) begin
            if (w_beats >= 1) break;
            tick();
        end
        check("midrst_one_beat", 64'(w_beats), 64'd1);
        check("midrst_w_active", 64'(m.m_axi_wvalid), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_async_outputs", 64'({cmd_ready, done, err, wr_ready, rd_valid, m.m_axi_awvalid,
              m.m_axi_wvalid, m.m_axi_bready, m.m_axi_arvalid, m.m_axi_rready}), 64'd0);
        repeat (3) tick();
        check("midrst_no_done", 64'(done_n), 64'd0);
        rst = 1'b1;
        tick();
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        wbase = 32'hC0;
        issue(1'b0, 24'h000400, 8'd1);
        wait_done("wr3");
        check("wr3_awaddr", 64'(aw_addr), 64'h400);
        check("wr3_beats", 64'(w_beats), 64'd2);
        check("wr3_mem", 64'({mem[10'h100], mem[10'h101]}), 64'h000000C0_000000C1);
        check("wr3_err", 64'(err), 64'd0);

        // Premature rlast on the 2nd beat of a 4-beat read
        cfg_rlast_at = 1;
        issue(1'b1, 24'h000100, 8'd3);
        wait_done("rlast_early");
        check("rlast_early_beats", 64'(rd_beats), 64'd2);
        check("rlast_early_data", 64'({rd_log[0], rd_log[1]}), 64'h000000A0_000000A1);
        check("rlast_early_err", 64'(err), 64'd1);
        check("rlast_early_idle", 64'(cmd_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_axi_burst_master.md
IOB_AXI_BURST_MASTER -- requirements
Module: iob_axi_burst_master

Interface
REQ-001 Parameter ADDR_W, default 24: AXI and command address width.
REQ-002 Parameter DATA_W, default 32: data width; only 32 SHALL be supported.
REQ-003 Clock and reset SHALL be: clk input 1, the single clock; rst input 1, asynchronous, active-low reset.
REQ-004 Ports SHALL be: cmd_valid input 1, command request; cmd_ready output 1, command accept.
REQ-005 Ports SHALL be: cmd_dir input 1, 0 write / 1 read; cmd_addr input ADDR_W, byte address; cmd_len input 8, beats minus one.
REQ-006 Ports SHALL be: wr_valid input 1; wr_data input DATA_W; wr_strb input DATA_W/8; wr_ready output 1. These form the write-data stream.
REQ-007 Ports SHALL be: rd_valid output 1; rd_data output DATA_W; rd_ready input 1. These form the read-data stream.
REQ-008 Ports SHALL be: done output 1, one-cycle completion pulse; err output 1, sticky error flag.
REQ-009 AXI4 master AW channel SHALL be: m_axi_awid 1, awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awlock 1, awcache 4, awprot 3, awqos 4, awvalid 1 (outputs); awready 1 (input).
REQ-010 AXI4 W channel SHALL be: m_axi_wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1 (outputs); wready 1 (input).
REQ-011 AXI4 B channel SHALL be: m_axi_bid 1, bresp 2, bvalid 1 (inputs); bready 1 (output).
REQ-012 AXI4 AR channel SHALL be: same set and widths as AW, prefixed m_axi_ar*.
REQ-013 AXI4 R channel SHALL be: m_axi_rid 1, rdata DATA_W, rresp 2, rlast 1, rvalid 1 (inputs); rready 1 (output).

Function
REQ-014 FSM states SHALL be IDLE, AW, W, B, AR, R, DONE; only one transaction outstanding at a time.
REQ-015 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, latch addr, len and dir, clear err, and go to AW (dir=0) or AR (dir=1).
REQ-016 Address register SHALL force bits [1:0] to 0; awaddr/araddr SHALL be driven from it.
REQ-017 Constants SHALL be: id=0, size=3'b010, burst=2'b01 (INCR), lock=0, cache=4'b0011, prot=0, qos=0; awlen/arlen = latched len.
REQ-018 4 KB check: if addr[11:0] + 4*(len+1) > 4096, go straight to DONE with err=1 and issue no AXI traffic.
REQ-019 awvalid/arvalid SHALL be registered, asserted the cycle after command accept, held until awready/arready, then the FSM SHALL go to W/R.
REQ-020 No W beat SHALL be issued before the AW handshake completes.
REQ-021 In W: wvalid=wr_valid, wr_ready=wready, wdata/wstrb = wr_data/wr_strb (combinational); 9-bit beat counter increments per handshake; wlast=1 when counter==len; after the last beat go to B.
REQ-022 In B: bready=1; on bvalid, err |= (bresp!=0), then go to DONE.
REQ-023 In R: rd_valid=rvalid, rready=rd_ready, rd_data=rdata; counter increments per handshake; err |= (rresp!=0).
REQ-024 In R: if rlast is absent at counter==len, or present earlier, set err=1; leave R on the rlast handshake.
REQ-025 DONE SHALL last one cycle: done=1, then return to IDLE; err SHALL hold until the next command accept.
REQ-026 Outside their states, wr_ready, rd_valid, wvalid, rready, bready, awvalid and arvalid SHALL be 0.
REQ-027 Latency SHALL be: done one cycle after the B handshake (write) or the rlast handshake (read).

Reset
REQ-028 While rst=0: state IDLE; all valid/ready/done/err outputs 0; counter and address registers 0; cmd_ready=0.
REQ-029 Reset mid-burst SHALL abort immediately with no completion pulse; the AXI slave is reset by the same signal.
REQ-030 cmd_ready=1 on the first clk edge after rst deasserts.

Verification
REQ-031 Write addr 0x100, len 3, stream 0xA0..0xA3, wready always 1 -> awlen=3; 4 W beats; wlast on the 4th; bresp OKAY; done pulse; err=0.
REQ-032 Read back from 0x100, len 3, rd_ready toggling every cycle -> rd_data 0xA0..0xA3 in order; no beat lost or duplicated; done pulse; err=0.
REQ-033 Write addr 0xFF0, len 7 (crosses 4 KB) -> no awvalid; done pulse the cycle after accept; err=1.
REQ-034 B response returns bresp=2'b10 -> err=1 after done; next command accept clears err.
REQ-035 rst asserted during the 2nd W beat of a len 7 write -> outputs 0 asynchronously; no done pulse; a new write completes correctly after release.
REQ-036 R channel returns rlast on beat 2 of a len 3 read -> err=1; FSM returns to IDLE after done.
